// File: rtl/simd_sched_pkg.sv
// ============================================================================
// Module  : simd_sched_pkg
// Brief   : Shared types and array geometry for the SIMD array scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package simd_sched_pkg;

    localparam int MAC_BW   = 8;
    localparam int LANES    = 64;
    localparam int TAG_ID_W = 8;

    typedef enum logic [1:0] {
        MODE_MAC = 2'd0,
        MODE_NL1 = 2'd1,
        MODE_NL2 = 2'd2,
        MODE_NL3 = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        mode_t               mode;
    } sched_tag_t;

endpackage

`default_nettype wire

// File: rtl/simd_array_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick starting at ptr; pointer owned by caller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0]   pick_idx
);

    always_comb begin
        int   j;
        logic found;
        j        = 0;
        found    = 1'b0;
        pick_oh  = '0;
        pick_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            j = int'(ptr) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found      = 1'b1;
                pick_oh[j] = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/simd_array_sched.sv
// ============================================================================
// Module  : simd_array_sched
// Brief   : Round-robin issue scheduler for the 64-lane SIMD array; drains the
//           pipeline before any mode change. Optional SIMD_SCHED_PERF_EN adds
//           issue/drain performance counters.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_array_sched
    import simd_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [2*NUM_REQ-1:0]            req_mode,
    input  logic [NUM_REQ*LANES*MAC_BW-1:0] req_a,
    input  logic [NUM_REQ*LANES*MAC_BW-1:0] req_b,
    output logic [1:0]                      mode,
    output logic [LANES*MAC_BW-1:0]         iA,
    output logic [LANES*MAC_BW-1:0]         iB,
    output logic                            res_valid,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic [1:0]                      res_mode,
    output logic                            busy
`ifdef SIMD_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_issue_cnt,
    output logic [31:0]                     perf_drain_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int VEC_W = LANES * MAC_BW;

    sched_state_t     state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] pend_q, pend_d;
    logic [VEC_W-1:0] ia_q, ia_d, ib_q, ib_d;
    logic [PIPE_LAT:0] vld_q, vld_d;
    sched_tag_t       tag_q [PIPE_LAT+1];
    sched_tag_t       tag_d [PIPE_LAT+1];

    logic [NUM_REQ-1:0] pick_oh, grant_oh;
    logic [IDX_W-1:0]   pick_idx, grant_idx;
    mode_t              pick_mode, grant_mode;
    logic               grant, in_flight;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

    always_comb begin
        // The last stage is leaving the array this cycle, so it cannot mix with a new mode.
        in_flight = |vld_q[PIPE_LAT-1:0];
        pick_mode = mode_t'(req_mode[2*int'(pick_idx) +: 2]);
        grant     = 1'b0;
        grant_oh  = '0;
        grant_idx = pick_idx;
        state_d   = state_q;
        pend_d    = pend_q;
        case (state_q)
            RUN: begin
                if (|req_valid) begin
                    if (pick_mode == mode_q || !in_flight) begin
                        grant    = 1'b1;
                        grant_oh = pick_oh;
                    end else begin
                        state_d = DRAIN;
                        pend_d  = pick_idx;
                    end
                end
            end
            DRAIN: begin
                if (!in_flight && req_valid[pend_q]) begin
                    grant     = 1'b1;
                    grant_idx = pend_q;
                    grant_oh  = NUM_REQ'(1) << pend_q;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        grant_mode = mode_t'(req_mode[2*int'(grant_idx) +: 2]);
        rr_ptr_d   = rr_ptr_q;
        mode_d     = mode_q;
        ia_d       = '0;
        ib_d       = '0;
        if (grant) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            mode_d   = grant_mode;
            ia_d     = req_a[int'(grant_idx)*VEC_W +: VEC_W];
            ib_d     = req_b[int'(grant_idx)*VEC_W +: VEC_W];
        end

        vld_d          = {vld_q[PIPE_LAT-1:0], grant};
        tag_d[0].id    = grant ? TAG_ID_W'(grant_idx) : '0;
        tag_d[0].mode  = grant ? grant_mode : MODE_MAC;
        for (int k = 1; k <= PIPE_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mode_q   <= MODE_MAC;
            rr_ptr_q <= '0;
            pend_q   <= '0;
            ia_q     <= '0;
            ib_q     <= '0;
            vld_q    <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
            ia_q     <= ia_d;
            ib_q     <= ib_d;
            vld_q    <= vld_d;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign req_ready = grant_oh & {NUM_REQ{~rst}};
    assign mode      = mode_q;
    assign iA        = ia_q;
    assign iB        = ib_q;
    assign res_valid = vld_q[PIPE_LAT];
    assign res_id    = tag_q[PIPE_LAT].id[IDX_W-1:0];
    assign res_mode  = tag_q[PIPE_LAT].mode;
    assign busy      = (|vld_q) | (state_q == DRAIN);

    generate
        if (TAG_ID_W > IDX_W) begin : g_tag_pad
            logic tag_unused;
            assign tag_unused = |tag_q[PIPE_LAT].id[TAG_ID_W-1:IDX_W];
        end
    endgenerate

`ifdef SIMD_SCHED_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d, perf_drain_q, perf_drain_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_drain_d = perf_drain_q;
        if (grant && perf_issue_q != '1) begin
            perf_issue_d = perf_issue_q + 32'd1;
        end
        if (state_q == DRAIN && perf_drain_q != '1) begin
            perf_drain_d = perf_drain_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_drain_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_drain_q <= perf_drain_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_drain_cnt = perf_drain_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simd_array_sched.sv
// ============================================================================
// Module  : tb_simd_array_sched
// Brief   : Directed scoreboard bench for simd_array_sched.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simd_array_sched;
    import simd_sched_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int PIPE_LAT = 4;
    localparam int VEC_W    = LANES * MAC_BW;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_mode;
    logic [NUM_REQ*VEC_W-1:0] req_a;
    logic [NUM_REQ*VEC_W-1:0] req_b;
    logic [1:0]               mode;
    logic [VEC_W-1:0]         iA;
    logic [VEC_W-1:0]         iB;
    logic                     res_valid;
    logic [1:0]               res_id;
    logic [1:0]               res_mode;
    logic                     busy;
`ifdef SIMD_SCHED_PERF_EN
    logic [31:0]              perf_issue_cnt;
    logic [31:0]              perf_drain_cnt;
`endif

    simd_array_sched #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_a     (req_a),
        .req_b     (req_b),
        .mode      (mode),
        .iA        (iA),
        .iB        (iB),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_mode  (res_mode),
        .busy      (busy)
`ifdef SIMD_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_drain_cnt (perf_drain_cnt)
`endif
    );

    typedef struct {
        int id;
        int md;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;
    logic [VEC_W-1:0] exp_a, exp_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the grant vector seen before the next edge; a grant there yields a result PIPE_LAT edges later.
    task automatic check_ready(input string nm, input logic [3:0] exp, input int md, input bit push);
        exp_t e;
        @(negedge clk);
        check(nm, VEC_W'(req_ready), VEC_W'(exp));
        if (push && exp != 4'b0000) begin
            e.id = 0;
            for (int i = 0; i < NUM_REQ; i++) if (exp[i]) e.id = i;
            e.md  = md;
            e.cyc = cyc + 1 + PIPE_LAT;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", VEC_W'(1), VEC_W'(0));
            end else begin
                e = exp_q.pop_front();
                check("res_id", VEC_W'(res_id), VEC_W'(e.id));
                check("res_mode", VEC_W'(res_mode), VEC_W'(e.md));
                check("res_cycle", VEC_W'(cyc), VEC_W'(e.cyc));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_mode  = '0;
        req_a     = {NUM_REQ*LANES{8'hA5}};
        req_b     = {NUM_REQ*LANES{8'h5A}};

        // Reset held with every requester asking.
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", VEC_W'(req_ready), VEC_W'(0));
        end
        check("rst_mode", VEC_W'(mode), VEC_W'(0));
        check("rst_iA", iA, '0);
        check("rst_iB", iB, '0);
        check("rst_res_valid", VEC_W'(res_valid), VEC_W'(0));
        check("rst_res_id", VEC_W'(res_id), VEC_W'(0));
        check("rst_res_mode", VEC_W'(res_mode), VEC_W'(0));
        check("rst_busy", VEC_W'(busy), VEC_W'(0));
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Round robin, all mode 0.
        check_ready("rr_g0", 4'b0001, 0, 1);
        tick(); check_ready("rr_g1", 4'b0010, 0, 1);
        tick(); check_ready("rr_g2", 4'b0100, 0, 1);
        tick(); check_ready("rr_g3", 4'b1000, 0, 1);
        tick(); check_ready("rr_g4", 4'b0001, 0, 1);
        tick(); req_valid = '0;
        repeat (8) tick();

        // Mode switch from a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); req_valid = 4'b0001; req_mode = 8'h00;
        check_ready("ms_g0", 4'b0001, 0, 1);
        tick(); req_valid = 4'b0110; req_mode = 8'h08;
        check_ready("ms_enter_drain", 4'b0000, 0, 1);
        for (int c = 0; c < 3; c++) begin
            tick(); check_ready("ms_drain", 4'b0000, 0, 1);
        end
        tick(); check_ready("ms_g1", 4'b0010, 2, 1);
        tick(); req_valid = 4'b0100;
        check_ready("ms_drain2", 4'b0000, 0, 1);
        check("ms_mode", VEC_W'(mode), VEC_W'(2));
        check("ms_busy", VEC_W'(busy), VEC_W'(1));
`ifdef SIMD_SCHED_PERF_EN
        check("perf_issue", VEC_W'(perf_issue_cnt), VEC_W'(2));
        check("perf_drain", VEC_W'(perf_drain_cnt), VEC_W'(4));
`endif
        for (int c = 0; c < 3; c++) begin
            tick(); check_ready("ms_drain3", 4'b0000, 0, 1);
        end
        tick(); check_ready("ms_g2", 4'b0100, 0, 1);
        tick(); req_valid = '0; req_mode = '0;
        repeat (8) tick();

        // Data path: lanes i / 2i on requester 3, others carry filler.
        for (int i = 0; i < LANES; i++) begin
            req_a[3*VEC_W + i*MAC_BW +: MAC_BW] = 8'(i);
            req_b[3*VEC_W + i*MAC_BW +: MAC_BW] = 8'(2*i);
            exp_a[i*MAC_BW +: MAC_BW] = 8'(i);
            exp_b[i*MAC_BW +: MAC_BW] = 8'(2*i);
        end
        req_valid = 4'b1000;
        check_ready("dp_g", 4'b1000, 0, 1);
        tick(); req_valid = '0;
        @(negedge clk);
        check("dp_iA", iA, exp_a);
        check("dp_iB", iB, exp_b);
        check("dp_mode", VEC_W'(mode), VEC_W'(0));
        tick();
        @(negedge clk);
        check("dp_iA_idle", iA, '0);
        check("dp_iB_idle", iB, '0);
        repeat (8) tick();

        // Reset in DRAIN with three ops in flight; none of their results may surface.
        req_valid = 4'hF; req_mode = 8'h40;
        check_ready("rd_g0", 4'b0001, 0, 0);
        tick(); check_ready("rd_g1", 4'b0010, 0, 0);
        tick(); check_ready("rd_g2", 4'b0100, 0, 0);
        tick(); check_ready("rd_enter_drain", 4'b0000, 0, 0);
        tick(); rst = 1'b1; req_valid = '0; req_mode = '0;
        @(negedge clk);
        check("rd_busy_drain", VEC_W'(busy), VEC_W'(1));
        tick(); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rd_res_valid", VEC_W'(res_valid), VEC_W'(0));
            tick();
        end
        check("rd_busy_idle", VEC_W'(busy), VEC_W'(0));
        req_valid = 4'b1010;
        check_ready("rd_ptr", 4'b0010, 0, 1);
        tick(); req_valid = '0;
        repeat (8) tick();

        check("sb_empty", VEC_W'(exp_q.size()), VEC_W'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simd_array_sched.md
# simd_array_sched

Issue scheduler for the 64-lane SIMD array with its MAC, nonlinear and adder-tree datapath.
- Shares the array between `NUM_REQ` requesters using round-robin arbitration.
- Drives the array's `mode`, `iA` and `iB` from registers.
- Drains the pipeline before any mode change, so the MAC and nonlinear paths never hold mixed-mode data.
- Emits a result strobe tagged with the requester id, aligned with the array's `oL1`/`oL2`/`oL3` outputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `PIPE_LAT`, 4: cycles from array input to valid `oL3`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot grant; the handshake is `req_valid & req_ready`.
- `req_mode`  in  NUM_REQ×2  requested mode. 0 = MAC; 1–3 = nonlinear.
- `req_a`  in  NUM_REQ×64×`MAC_BW`  operand A lanes.
- `req_b`  in  NUM_REQ×64×`MAC_BW`  operand B lanes.
- `mode`  out  2  array mode.
- `iA`  out  64×`MAC_BW`  array operand A.
- `iB`  out  64×`MAC_BW`  array operand B.
- `res_valid`  out  1  array outputs valid this cycle.
- `res_id`  out  $clog2(NUM_REQ)  owner of the current result.
- `res_mode`  out  2  mode of the current result.
- `busy`  out  1  in-flight ops exist, or the block is in DRAIN.

## Operation
- **Requester handshake:** once asserted, `req_valid` and its payload hold until the grant. Grants are at most one per cycle.
- **Round-robin pick:** among the asserted `req_valid`, start at `rr_ptr` and pick the first. After any grant, `rr_ptr` = granted index + 1, wrapping at `NUM_REQ`.
- **States:** RUN and DRAIN.
- **RUN, pick mode equals `cur_mode`, or the in-flight shift register is all zero:** grant the pick, register the payload, set `cur_mode` to the pick's mode, push 1 plus the id/mode tag into the in-flight shift register. Stay in RUN.
- **RUN, pick mode differs and ops are in flight:** latch the pick index as `pend`, go to DRAIN, grant nothing.
- **DRAIN:** grant nothing until the in-flight shift register is all zero. In that cycle grant `pend`, switch `cur_mode`, go to RUN. No other requester can overtake `pend`.
- **Any two different modes trigger a drain.** This includes nonlinear-to-nonlinear changes, because the nonlinear unit consumes `mode`.
- **No grant in a cycle:** `iA` and `iB` are zero next cycle; `mode` holds `cur_mode`.
- **Result path:** the in-flight shift register is `PIPE_LAT+1` deep. Its output drives `res_valid`, `res_id` and `res_mode`.
- **No result backpressure:** the array cannot stall.
- **Reset:** any reset, including mid-DRAIN or with ops in flight, clears everything. The block drops pending grants and flushes the in-flight tags. Results that later emerge from the array are not flagged.

## Timing
- **Reset values:** `req_ready` = 0, `mode` = 0, `iA`/`iB` = 0, `res_valid` = 0, `res_id` = 0, `res_mode` = 0, `busy` = 0. Also `rr_ptr` = 0, state = RUN, `cur_mode` = 0.
- **Grant timing:** `req_ready` is combinational from `req_valid`, state and the in-flight register.
- **Array input timing:** a handshake at edge t puts the payload on `mode`/`iA`/`iB` during cycle t+1.
- **Result timing:** `res_valid` is high during cycle t+1+`PIPE_LAT`.
- **Throughput:** back-to-back same-mode grants give one issue per cycle.
- **Mode-switch bubble:** the pending grant lands in the first cycle the in-flight register reads all zero. That is `PIPE_LAT+1` cycles after the last prior grant edge.
- **In-flight register size:** it never exceeds `PIPE_LAT+1` entries; no overflow case exists.

## Configuration
- **Macro:** `SIMD_SCHED_PERF_EN`.
- **Defined:** adds `perf_issue_cnt` (out, 32) and `perf_drain_cnt` (out, 32).
  - `perf_issue_cnt` counts grants.
  - `perf_drain_cnt` counts cycles spent in DRAIN.
  - Both are cleared by `rst` and saturate at all-ones.
- **Undefined:** the ports and logic are absent; the block's behaviour is otherwise identical.

## Structure
- **Package `simd_sched_pkg`:**
  - `mode_t` enum: MODE_MAC=0, MODE_NL1..MODE_NL3.
  - `sched_state_t` enum: RUN, DRAIN.
  - Tag struct {id, mode}.
- **`MAC_BW`** comes from the shared parameter definitions.
- **Sub-module `rr_arbiter`:** parameterised by `NUM_REQ`. Inputs: request vector, `rr_ptr`. Outputs: one-hot pick and its index. It is combinational; the scheduler owns the pointer.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all `req_valid` = 1 → all outputs at reset values, no `req_ready`. After release, the first grant goes to requester 0.
- **Round-robin:** requesters 0–3 all valid, mode 0, continuously → grants 0,1,2,3,0 on consecutive cycles. `res_id` 0,1,2,3 appears 5 cycles after the respective grant edges.
- **Mode switch:**
  - Requester 0 (mode 0) is granted at edge 10; requester 1 (mode 2) is valid from edge 11 → DRAIN.
  - Requester 1 is granted at edge 15; requester 2 (mode 0) is ignored meanwhile.
  - `mode` = 2 in cycle 16.
- **Data path:** lanes `req_a`=i, `req_b`=2i → `iA[i]`=i and `iB[i]`=2i one cycle after the grant. Next cycle with no grant → `iA` and `iB` all zero.
- **Reset mid-DRAIN:** assert `rst` while in DRAIN with 3 ops in flight → `res_valid` stays 0 thereafter, state = RUN, `rr_ptr` = 0.
- **Perf counters (with `SIMD_SCHED_PERF_EN`):** the mode-switch scenario above → `perf_issue_cnt` = 2, `perf_drain_cnt` = 4.
